// File: rtl/drp_sample_responder_if.sv
// DRP bus between a reader (master) and the sample responder (slave).
interface drp_sample_responder_if;
  logic [6:0]  daddr_in;
  logic        den_in;
  logic        dwe_in;
  logic [15:0] di_in;
  logic [15:0] do_out;
  logic        drdy_out;

  modport master (
    output daddr_in, den_in, dwe_in, di_in,
    input  do_out, drdy_out
  );

  modport slave (
    input  daddr_in, den_in, dwe_in, di_in,
    output do_out, drdy_out
  );
endinterface

// File: rtl/drp_sample_responder.sv
// XADC-style DRP responder around an external 12-bit sample source with a conversion sequencer.
// Optional feature: define DRP_MINMAX_EN to build min/max tracking at 7'h26 / 7'h2E.
module drp_sample_responder #(
  parameter int unsigned READ_LATENCY = 4,
  parameter int unsigned CONV_CYCLES  = 26,
  parameter logic [4:0]  CHANNEL      = 5'h16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [11:0]                  sample_in,
  input  logic                         sample_valid,
  drp_sample_responder_if.slave        drp,
  output logic                         busy_out,
  output logic                         eoc_out,
  output logic [4:0]                   channel_out
);

  localparam logic [3:0] LAT_LAST  = 4'(READ_LATENCY - 1);
  localparam logic [7:0] CONV_LAST = 8'(CONV_CYCLES);

  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_RESP} drp_state_t;
  typedef enum logic [1:0] {C_IDLE, C_CONV, C_DONE} conv_state_t;

  drp_state_t  d_state_r;
  conv_state_t c_state_r;
  logic [3:0]  d_cnt_r;
  logic [7:0]  c_cnt_r;
  logic        wr_r;
  logic [15:0] latch_r;
  logic [15:0] do_r;
  logic        drdy_r;
  logic [15:0] cfg0_r;
  logic [15:0] cfg1_r;
  logic [11:0] shadow_r;
  logic [11:0] result_r;
`ifdef DRP_MINMAX_EN
  logic [11:0] max_r;
  logic [11:0] min_r;
`endif
  logic [15:0] rd_val_s;

  assign drp.do_out   = do_r;
  assign drp.drdy_out = drdy_r;

  // Register-map read decode for the currently presented address
  always_comb begin
    rd_val_s = 16'h0000;
    case (drp.daddr_in)
      7'h16:   rd_val_s = {result_r, 4'h0};
`ifdef DRP_MINMAX_EN
      7'h26:   rd_val_s = {max_r, 4'h0};
      7'h2E:   rd_val_s = {min_r, 4'h0};
`endif
      7'h40:   rd_val_s = cfg0_r;
      7'h41:   rd_val_s = cfg1_r;
      default: rd_val_s = 16'h0000;
    endcase
  end

  // DRP transaction FSM: accept, fixed-latency wait, one-cycle response
  always_ff @(posedge clk) begin
    if (reset) begin
      d_state_r <= D_IDLE;
      d_cnt_r   <= 4'd0;
      wr_r      <= 1'b0;
      latch_r   <= 16'h0000;
      do_r      <= 16'h0000;
      drdy_r    <= 1'b0;
      cfg0_r    <= 16'h0000;
      cfg1_r    <= 16'h0000;
    end else begin
      case (d_state_r)
        D_IDLE: begin
          drdy_r <= 1'b0;
          if (drp.den_in) begin
            wr_r <= drp.dwe_in;
            if (drp.dwe_in) begin
              case (drp.daddr_in)
                7'h40:   cfg0_r <= drp.di_in;
                7'h41:   cfg1_r <= drp.di_in;
                default: ;
              endcase
            end else begin
              latch_r <= rd_val_s;
            end
            // A latency of one skips WAIT entirely
            if (LAT_LAST == 4'd0) begin
              d_state_r <= D_RESP;
              drdy_r    <= 1'b1;
              if (!drp.dwe_in) begin
                do_r <= rd_val_s;
              end
            end else begin
              d_state_r <= D_WAIT;
              d_cnt_r   <= 4'd1;
            end
          end
        end
        D_WAIT: begin
          if (d_cnt_r == LAT_LAST) begin
            d_state_r <= D_RESP;
            drdy_r    <= 1'b1;
            if (!wr_r) begin
              do_r <= latch_r;
            end
          end else begin
            d_cnt_r <= d_cnt_r + 4'd1;
          end
        end
        D_RESP: begin
          drdy_r    <= 1'b0;
          d_state_r <= D_IDLE;
        end
        default: begin
          drdy_r    <= 1'b0;
          d_state_r <= D_IDLE;
        end
      endcase
    end
  end

  // Conversion sequencer: capture, busy window, end-of-conversion pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      c_state_r   <= C_IDLE;
      c_cnt_r     <= 8'd0;
      shadow_r    <= 12'h000;
      result_r    <= 12'h000;
      busy_out    <= 1'b0;
      eoc_out     <= 1'b0;
      channel_out <= 5'h00;
`ifdef DRP_MINMAX_EN
      max_r       <= 12'h000;
      min_r       <= 12'hFFF;
`endif
    end else begin
      case (c_state_r)
        C_IDLE: begin
          if (sample_valid) begin
            shadow_r  <= sample_in;
            c_state_r <= C_CONV;
            busy_out  <= 1'b1;
            c_cnt_r   <= 8'd1;
          end
        end
        C_CONV: begin
          // Result is published on the edge into DONE so a read tied to eoc sees it
          if (c_cnt_r == CONV_LAST) begin
            c_state_r   <= C_DONE;
            busy_out    <= 1'b0;
            eoc_out     <= 1'b1;
            channel_out <= CHANNEL;
            result_r    <= shadow_r;
`ifdef DRP_MINMAX_EN
            if (shadow_r > max_r) begin
              max_r <= shadow_r;
            end
            if (shadow_r < min_r) begin
              min_r <= shadow_r;
            end
`endif
          end else begin
            c_cnt_r <= c_cnt_r + 8'd1;
          end
        end
        C_DONE: begin
          eoc_out     <= 1'b0;
          channel_out <= 5'h00;
          c_state_r   <= C_IDLE;
        end
        default: begin
          busy_out    <= 1'b0;
          eoc_out     <= 1'b0;
          channel_out <= 5'h00;
          c_state_r   <= C_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drp_sample_responder.sv
// Scoreboard bench for drp_sample_responder: randomized DRP/conversion traffic against a cycle-level model.
module tb_drp_sample_responder;

  localparam int unsigned L  = 4;
  localparam int unsigned C  = 26;
  localparam logic [4:0]  CH = 5'h16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] sample_in = 12'h000;
  logic        sample_valid = 1'b0;
  logic        busy_out;
  logic        eoc_out;
  logic [4:0]  channel_out;

  drp_sample_responder_if drp_bus();

  drp_sample_responder #(
    .READ_LATENCY(L),
    .CONV_CYCLES (C),
    .CHANNEL     (CH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .drp         (drp_bus),
    .busy_out    (busy_out),
    .eoc_out     (eoc_out),
    .channel_out (channel_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  logic        rst_d = 1'b1;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_d <= reset;

  typedef struct packed {
    logic [31:0] due;
    logic [15:0] data;
  } exp_t;

  exp_t        drq[$];
  int unsigned eocq[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [11:0] m_result = 12'h000;
  logic [11:0] m_max = 12'h000;
  logic [11:0] m_min = 12'hFFF;
  logic [15:0] m_cfg0 = 16'h0000;
  logic [15:0] m_cfg1 = 16'h0000;
  logic [15:0] last_do = 16'h0000;
  logic        pend_valid = 1'b0;
  int unsigned pend_cycle = 0;
  logic [11:0] pend_sample = 12'h000;
  int unsigned drp_free = 0;
  int unsigned conv_free = 0;
  int unsigned busy_from = 1;
  int unsigned busy_to = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [6:0] a);
    case (a)
      7'h16: return {m_result, 4'h0};
`ifdef DRP_MINMAX_EN
      7'h26: return {m_max, 4'h0};
      7'h2E: return {m_min, 4'h0};
`endif
      7'h40: return m_cfg0;
      7'h41: return m_cfg1;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic apply_pending(input int unsigned t);
    if (pend_valid && pend_cycle <= t) begin
      m_result = pend_sample;
`ifdef DRP_MINMAX_EN
      if (pend_sample > m_max) m_max = pend_sample;
      if (pend_sample < m_min) m_min = pend_sample;
`endif
      pend_valid = 1'b0;
    end
  endtask

  task automatic model_reset(input int unsigned k);
    exp_t        keep[$];
    int unsigned keep_e[$];
    foreach (drq[i]) if (drq[i].due <= k) keep.push_back(drq[i]);
    foreach (eocq[i]) if (eocq[i] <= k) keep_e.push_back(eocq[i]);
    drq  = keep;
    eocq = keep_e;
    if (busy_to > k) busy_to = k;
    pend_valid = 1'b0;
    m_result = 12'h000;
    m_max    = 12'h000;
    m_min    = 12'hFFF;
    m_cfg0   = 16'h0000;
    m_cfg1   = 16'h0000;
    last_do  = 16'h0000;
    drp_free = 0;
    conv_free = 0;
  endtask

  task automatic drive(input logic den, input logic we, input logic [6:0] addr,
                       input logic [15:0] di, input logic sv, input logic [11:0] s,
                       input logic rst);
    exp_t e;
    @(posedge clk);
    #1;
    apply_pending(cyc);
    reset            = rst;
    drp_bus.den_in   = den;
    drp_bus.dwe_in   = we;
    drp_bus.daddr_in = addr;
    drp_bus.di_in    = di;
    sample_valid     = sv;
    sample_in        = s;
    if (rst) begin
      model_reset(cyc);
    end else begin
      if (den && cyc >= drp_free) begin
        if (we) begin
          if (addr == 7'h40) m_cfg0 = di;
          else if (addr == 7'h41) m_cfg1 = di;
        end else begin
          last_do = model_read(addr);
        end
        e.due  = cyc + L;
        e.data = last_do;
        drq.push_back(e);
        drp_free = cyc + L + 1;
      end
      if (sv && cyc >= conv_free) begin
        pend_valid  = 1'b1;
        pend_cycle  = cyc + C + 1;
        pend_sample = s;
        eocq.push_back(cyc + C + 1);
        busy_from = cyc + 1;
        busy_to   = cyc + C;
        conv_free = cyc + C + 2;
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 7'h00, 16'h0000, 1'b0, 12'h000, 1'b0);
  endtask
  task automatic rd(input logic [6:0] a);
    drive(1'b1, 1'b0, a, 16'h0000, 1'b0, 12'h000, 1'b0);
  endtask
  task automatic wr(input logic [6:0] a, input logic [15:0] d);
    drive(1'b1, 1'b1, a, d, 1'b0, 12'h000, 1'b0);
  endtask
  task automatic conv(input logic [11:0] s);
    drive(1'b0, 1'b0, 7'h00, 16'h0000, 1'b1, s, 1'b0);
  endtask
  task automatic rst_cycle();
    drive(1'b0, 1'b0, 7'h00, 16'h0000, 1'b0, 12'h000, 1'b1);
  endtask

  // Monitor: pops expectations whenever the DUT presents drdy/eoc
  always @(negedge clk) begin
    exp_t        e;
    int unsigned due;
    if (rst_d) begin
      check("reset_outputs", {8'h00, drp_bus.drdy_out, drp_bus.do_out, busy_out, eoc_out, channel_out}, 32'h0);
    end else begin
      if (drp_bus.drdy_out) begin
        if (drq.size() == 0) begin
          check("drdy_unexpected", 32'd1, 32'd0);
        end else begin
          e = drq.pop_front();
          check("drdy_cycle_data", {cyc[15:0], drp_bus.do_out}, {e.due[15:0], e.data});
        end
      end
      if (eoc_out) begin
        if (eocq.size() == 0) begin
          check("eoc_unexpected", 32'd1, 32'd0);
        end else begin
          due = eocq.pop_front();
          check("eoc_cycle_channel", {cyc[15:0], 11'h0, channel_out}, {due[15:0], 11'h0, CH});
        end
      end else begin
        check("channel_idle", {27'h0, channel_out}, 32'h0);
      end
      check("busy", {31'h0, busy_out}, {31'h0, (cyc >= busy_from && cyc <= busy_to)});
    end
  end

  initial begin
    logic        d, w, v;
    logic [6:0]  a;
    logic [31:0] r;
    logic [11:0] smp[3];
    drp_bus.den_in   = 1'b0;
    drp_bus.dwe_in   = 1'b0;
    drp_bus.daddr_in = 7'h00;
    drp_bus.di_in    = 16'h0000;
    smp[0] = 12'h100;
    smp[1] = 12'hF00;
    smp[2] = 12'h080;

    repeat (3) rst_cycle();
    repeat (6) idle();
    rd(7'h16);
    repeat (L) idle();

    // Conversion with the read issued on the eoc cycle
    conv(12'hABC);
    repeat (C) idle();
    rd(7'h16);
    repeat (L) idle();

    for (int i = 0; i < 3; i++) begin
      conv(smp[i]);
      repeat (C + 1) idle();
    end
    rd(7'h26);
    repeat (L) idle();
    rd(7'h2E);
    repeat (L) idle();

    wr(7'h41, 16'h1234);
    repeat (L) idle();
    rd(7'h41);
    repeat (L) idle();
    wr(7'h16, 16'hFFFF);
    repeat (L) idle();
    rd(7'h16);
    repeat (L) idle();

    // Second den two cycles in, and sample_valid while busy
    rd(7'h41);
    idle();
    wr(7'h40, 16'h5555);
    repeat (L) idle();
    rd(7'h40);
    repeat (L) idle();
    conv(12'h555);
    repeat (5) idle();
    conv(12'h777);
    repeat (C) idle();
    rd(7'h16);
    repeat (L) idle();

    // Reset during WAIT, then during CONV
    rd(7'h16);
    idle();
    repeat (2) rst_cycle();
    repeat (2) idle();
    rd(7'h16);
    repeat (L) idle();
    conv(12'h9AB);
    repeat (5) idle();
    repeat (2) rst_cycle();
    repeat (C + 5) idle();
    rd(7'h16);
    repeat (L) idle();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        repeat ($urandom_range(1, 3)) rst_cycle();
      end else begin
        r = $urandom;
        case ($urandom_range(0, 5))
          0: a = 7'h16;
          1: a = 7'h26;
          2: a = 7'h2E;
          3: a = 7'h40;
          4: a = 7'h41;
          default: a = r[22:16];
        endcase
        d = ($urandom_range(0, 3) == 0);
        w = ($urandom_range(0, 2) == 0);
        if (pend_valid && pend_cycle == cyc + 1 && $urandom_range(0, 1) == 1) begin
          d = 1'b1;
          w = 1'b0;
          a = 7'h16;
        end
        v = ($urandom_range(0, 7) == 0);
        drive(d, w, a, r[15:0], v, r[27:16], 1'b0);
      end
    end

    repeat (C + L + 5) idle();
    check("drdy_drained", drq.size(), 32'd0);
    check("eoc_drained", eocq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/drp_sample_responder.md
# drp_sample_responder

Responder end of the XADC-style DRP port: accepts `den_in`/`dwe_in` transactions and answers with `drdy_out`/`do_out` after a fixed latency, like the XADC primitive. It wraps an external 12-bit sample source, such as a SPI ADC front end or a test-pattern generator, in a conversion sequencer that drives `busy_out`, `eoc_out` and `channel_out`. Existing DRP readers (LED bar, seven-segment scaler) can therefore run unchanged on boards or benches without the XADC hard block.

## Interface
Parameters:
- `READ_LATENCY`, 4: cycles from accepted `den_in` to `drdy_out`; legal range 1–15.
- `CONV_CYCLES`, 26: cycles `busy_out` stays high per conversion; legal range 2–255.
- `CHANNEL`, 5'h16: value driven on `channel_out` during `eoc_out`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: sole clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `sample_in` in 12: raw unsigned sample.
- `sample_valid` in 1: one-cycle strobe that starts a conversion.
- `daddr_in` in 7: DRP register address.
- `den_in` in 1: DRP enable, one-cycle pulse per transaction.
- `dwe_in` in 1: DRP write enable, qualified by `den_in`.
- `di_in` in 16: DRP write data.
- `do_out` out 16: DRP read data.
- `drdy_out` out 1: one-cycle transaction-complete pulse.
- `busy_out` out 1: conversion in progress.
- `eoc_out` out 1: one-cycle end-of-conversion pulse.
- `channel_out` out 5: `CHANNEL` while `eoc_out` is high, else 0.

## Operation
Register map (unlisted addresses read 16'h0000 and ignore writes):
- 7'h16 RO result: `{sample, 4'b0}`.
- 7'h26 RO max: `{max, 4'b0}`.
- 7'h2E RO min: `{min, 4'b0}`.
- 7'h40, 7'h41 RW config: plain storage; reset value 16'h0000.

DRP FSM has three states:
- IDLE: `den_in` accepts the transaction and moves to WAIT.
  - On a read, the addressed register value is captured into the read latch on the accept edge.
  - On a write, the target register updates on the accept edge.
- WAIT: counts `READ_LATENCY`-1 cycles, then moves to RESP.
  - `den_in` in WAIT is ignored: no second `drdy_out`, no write performed.
- RESP: drives `drdy_out`=1 for one cycle and returns to IDLE.
  - On a read, `do_out` is loaded from the latch on the edge that raises `drdy_out`.
  - On a write, `do_out` is unchanged.
  - `den_in` arriving in RESP is ignored.
- `do_out` holds its value between transactions.

Conversion FSM has three states:
- IDLE: `sample_valid` captures `sample_in` into a shadow register and moves to CONV.
- CONV: `busy_out`=1 for exactly `CONV_CYCLES` cycles; `sample_valid` is dropped.
- DONE: one cycle with `eoc_out`=1 and `channel_out`=`CHANNEL`, then back to IDLE.
  - The result register (and min/max) updates on the edge entering DONE, so the value is already visible while `eoc_out` is high.
  - A read whose `den_in` coincides with `eoc_out` returns the new sample. This supports readers that tie `den_in` to `eoc_out`.
  - `sample_valid` in DONE is dropped.

Reset values:
- `do_out`=0, `drdy_out`=0, `busy_out`=0, `eoc_out`=0, `channel_out`=0.
- Result 0, max 16'h0000, min 16'hFFF0, config registers 0.
- Both FSMs return to IDLE.
- Reset mid-transaction aborts it with no `drdy_out`; reset mid-conversion discards the shadow sample.

## Timing
- Read: `den_in` at cycle N -> `drdy_out` and valid `do_out` at cycle N+`READ_LATENCY`. The next `den_in` is accepted at N+`READ_LATENCY`+1 at the earliest.
- Conversion: `sample_valid` at cycle M -> `busy_out` high in M+1 .. M+`CONV_CYCLES` -> `eoc_out` at M+`CONV_CYCLES`+1. The next `sample_valid` is accepted at M+`CONV_CYCLES`+2.
- Simultaneous events:
  - A write to 7'h16/26/2E is ignored (read-only).
  - Conversion update and an accepted read in the same cycle: the read sees the post-update value only when `den_in` occurs during `eoc_out`. Earlier reads see the old value.

## Configuration
- `DRP_MINMAX_EN` defined:
  - max = max(max, sample) and min = min(min, sample) on every DONE entry, 12-bit unsigned compare.
  - Equal samples leave both registers unchanged.
- `DRP_MINMAX_EN` undefined:
  - No tracking logic is built.
  - 7'h26 and 7'h2E read 16'h0000.

## Test plan
- Reset, then read 7'h16 at cycle 10 -> `drdy_out` at cycle 14 (`READ_LATENCY`=4), `do_out`=16'h0000; all outputs 0 while in reset.
- `sample_in`=12'hABC with `sample_valid` at cycle M -> `busy_out` for 26 cycles, `eoc_out`/`channel_out`=5'h16 at M+27; read 7'h16 with `den_in` tied to `eoc_out` -> `do_out`=16'hABC0.
- Samples 12'h100, 12'hF00, 12'h080 -> with `DRP_MINMAX_EN`: 7'h26=16'hF000 and 7'h2E=16'h0800; without it, both read 16'h0000.
- Write 16'h1234 to 7'h41 -> `drdy_out` after 4 cycles with `do_out` unchanged; read back 7'h41 -> 16'h1234; write 7'h16 -> value unchanged.
- Second `den_in` 2 cycles after the first -> exactly one `drdy_out`; `sample_valid` while `busy_out` -> ignored, exactly one `eoc_out`.
- Assert `reset` during WAIT and during CONV -> no `drdy_out`, no `eoc_out`, result still 0, next transaction completes normally.
